// File: rtl/fbuff_arbiter.sv
// fbuff_arbiter
// Shares one single-port frame-buffer RAM between the camera write path,
// the VGA scan-out reader and the ALU kernel engine. Fixed priority
// VGA > CAM > ALU, except that an ALU which has waited STARVE_MAX cycles
// jumps ahead of the camera (never ahead of VGA). The RAM command is
// registered one cycle after the grant, and a tag pipeline steers the
// returning read data to whichever requester issued the read.
module fbuff_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 12,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic          sys_clk,
    input  logic          rst_n,

    input  logic          cam_req,
    input  logic [AW-1:0] cam_addr,
    input  logic [DW-1:0] cam_wdata,
    output logic          cam_ack,

    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_ack,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,

    input  logic          alu_req,
    input  logic          alu_we,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_wdata,
    output logic          alu_ack,
    output logic          alu_rvalid,
    output logic [DW-1:0] alu_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          starve_flag
);

    // Counter is 8 bits wide so it can hold the largest legal STARVE_MAX (255).
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // Tag pipeline: RD_LAT+1 stages of {vga, alu}; stage 0 occupies bits [1:0].
    localparam int TW = 2 * (RD_LAT + 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [7:0]    r_starve_cnt;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [TW-1:0] r_tag_pipe;
    logic [DW-1:0] r_vga_rdata;
    logic [DW-1:0] r_alu_rdata;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic          w_ovr;
    logic          w_vga_gnt;
    logic          w_cam_gnt;
    logic          w_alu_gnt;
    logic          w_any_gnt;
    logic          w_wr_gnt;
    logic          w_alu_rd_gnt;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic [7:0]    w_starve_next;
    logic          w_vga_rvalid;
    logic          w_alu_rvalid;

    // Override is decided purely from registered state, so acks stay a
    // shallow function of the req inputs.
    assign w_ovr = (r_starve_cnt == STARVE_LIM);

    // Grant decode: VGA always first; between CAM and ALU the override
    // decides. The three grants are mutually exclusive by construction.
    always_comb begin
        w_vga_gnt = vga_req;
        w_alu_gnt = alu_req & ~vga_req & (~cam_req | w_ovr);
        w_cam_gnt = cam_req & ~vga_req & ~(alu_req & w_ovr);
    end

    assign w_any_gnt    = w_vga_gnt | w_cam_gnt | w_alu_gnt;
    assign w_wr_gnt     = w_cam_gnt | (w_alu_gnt & alu_we);
    assign w_alu_rd_gnt = w_alu_gnt & ~alu_we;

    // Select the address/data of whichever requester holds the grant.
    always_comb begin
        w_sel_addr  = alu_addr;
        w_sel_wdata = alu_wdata;
        if (w_vga_gnt) begin
            w_sel_addr = vga_addr;
        end else if (w_cam_gnt) begin
            w_sel_addr  = cam_addr;
            w_sel_wdata = cam_wdata;
        end
    end

    // Starve counter next value: cleared whenever the ALU is served or
    // not asking, otherwise counts up and sticks at the limit.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!alu_req || w_alu_gnt) begin
            w_starve_next = 8'd0;
        end else if (!w_ovr) begin
            w_starve_next = r_starve_cnt + 8'd1;
        end
    end

    // Starve counter register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 8'd0;
        end else begin
            r_starve_cnt <= w_starve_next;
        end
    end

    // Registered RAM command: the grant of cycle N drives the RAM in N+1.
    // Address holds across idle cycles; write data changes only on writes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_any_gnt;
            r_mem_we <= w_wr_gnt;
            if (w_any_gnt) begin
                r_mem_addr <= w_sel_addr;
            end
            if (w_wr_gnt) begin
                r_mem_wdata <= w_sel_wdata;
            end
        end
    end

    // Read-tag shift pipeline; a tag reaches the last stage exactly when
    // the RAM presents the data for that read. Reset drops in-flight tags.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_pipe <= '0;
        end else begin
            r_tag_pipe <= {r_tag_pipe[TW-3:0], w_vga_gnt, w_alu_rd_gnt};
        end
    end

    assign w_vga_rvalid = r_tag_pipe[TW-1];
    assign w_alu_rvalid = r_tag_pipe[TW-2];

    // Read-data holding registers: each captures RAM data on its own
    // return pulse and keeps it otherwise.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_rdata <= '0;
            r_alu_rdata <= '0;
        end else begin
            if (w_vga_rvalid) begin
                r_vga_rdata <= mem_rdata;
            end
            if (w_alu_rvalid) begin
                r_alu_rdata <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The rdata ports pass mem_rdata through on the return cycle
    // so data and rvalid line up; between returns they show the held value.
    // ------------------------------------------------------------------
    assign vga_ack     = w_vga_gnt;
    assign cam_ack     = w_cam_gnt;
    assign alu_ack     = w_alu_gnt;
    assign starve_flag = w_ovr;

    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    assign vga_rvalid  = w_vga_rvalid;
    assign alu_rvalid  = w_alu_rvalid;
    assign vga_rdata   = w_vga_rvalid ? mem_rdata : r_vga_rdata;
    assign alu_rdata   = w_alu_rvalid ? mem_rdata : r_alu_rdata;

endmodule

// File: tb/tb_fbuff_arbiter.sv
// tb_fbuff_arbiter
// Two arbiter instances (RD_LAT = 1 and RD_LAT = 3) share one set of
// requester inputs, each behind its own behavioural RAM. Directed steps
// state the expected winner per cycle; read expectations go into a
// per-instance queue and are popped when the return is due.
module tb_fbuff_arbiter;

    localparam int AW = 19;
    localparam int DW = 12;
    localparam int MEM_WORDS = 131072;

    typedef struct packed {
        int          cyc;
        logic        is_vga;
        logic [11:0] data;
    } rd_exp_t;

    logic          sys_clk;
    logic          rst_n;
    logic          cam_req;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_wdata;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          alu_req;
    logic          alu_we;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_wdata;

    logic          cam_ack     [2];
    logic          vga_ack     [2];
    logic          vga_rvalid  [2];
    logic [DW-1:0] vga_rdata   [2];
    logic          alu_ack     [2];
    logic          alu_rvalid  [2];
    logic [DW-1:0] alu_rdata   [2];
    logic          mem_en      [2];
    logic          mem_we      [2];
    logic [AW-1:0] mem_addr    [2];
    logic [DW-1:0] mem_wdata   [2];
    logic [DW-1:0] mem_rdata   [2];
    logic          starve_flag [2];

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    // Pending read expectation handed from the stimulus to the scoreboards.
    logic          pend_rd   = 1'b0;
    logic          pend_vga  = 1'b0;
    logic [DW-1:0] pend_data = '0;
    int            pend_cyc  = 0;

    // Expected RAM command state and expected memory contents.
    logic          exp_en;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_mem [MEM_WORDS];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        logic [AW-1:0] v;
        v = a;
        return v[11:0] ^ 12'h9A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;

            fbuff_arbiter #(
                .AW(AW), .DW(DW), .RD_LAT(LAT), .STARVE_MAX(15)
            ) u_dut (
                .sys_clk     (sys_clk),
                .rst_n       (rst_n),
                .cam_req     (cam_req),
                .cam_addr    (cam_addr),
                .cam_wdata   (cam_wdata),
                .cam_ack     (cam_ack[gi]),
                .vga_req     (vga_req),
                .vga_addr    (vga_addr),
                .vga_ack     (vga_ack[gi]),
                .vga_rvalid  (vga_rvalid[gi]),
                .vga_rdata   (vga_rdata[gi]),
                .alu_req     (alu_req),
                .alu_we      (alu_we),
                .alu_addr    (alu_addr),
                .alu_wdata   (alu_wdata),
                .alu_ack     (alu_ack[gi]),
                .alu_rvalid  (alu_rvalid[gi]),
                .alu_rdata   (alu_rdata[gi]),
                .mem_en      (mem_en[gi]),
                .mem_we      (mem_we[gi]),
                .mem_addr    (mem_addr[gi]),
                .mem_wdata   (mem_wdata[gi]),
                .mem_rdata   (mem_rdata[gi]),
                .starve_flag (starve_flag[gi])
            );

            // Behavioural RAM: data valid LAT cycles after the enable cycle.
            logic [DW-1:0] ram [MEM_WORDS];
            logic [DW-1:0] rd_pipe [LAT];

            initial begin
                for (int k = 0; k < MEM_WORDS; k++) ram[k] = init_val(19'(k));
            end

            always @(posedge sys_clk) begin
                if (mem_en[gi] && mem_we[gi]) ram[mem_addr[gi][16:0]] <= mem_wdata[gi];
                if (mem_en[gi] && !mem_we[gi]) rd_pipe[0] <= ram[mem_addr[gi][16:0]];
                for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
            end

            assign mem_rdata[gi] = rd_pipe[LAT-1];

            // Scoreboard for this instance.
            rd_exp_t rd_q[$];

            always @(posedge sys_clk) begin
                if (pend_rd) rd_q.push_back('{cyc: pend_cyc + 1 + LAT, is_vga: pend_vga, data: pend_data});
            end

            always @(negedge rst_n) rd_q.delete();

            always @(negedge sys_clk) begin : mon
                rd_exp_t e;
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc_cnt) begin
                    e = rd_q.pop_front();
                    chk($sformatf("rvalid_d%0d", gi), 32'({vga_rvalid[gi], alu_rvalid[gi]}),
                        32'({e.is_vga, ~e.is_vga}));
                    chk($sformatf("rdata_d%0d", gi),
                        32'(e.is_vga ? vga_rdata[gi] : alu_rdata[gi]), 32'(e.data));
                    $display("rd return d%0d cyc=%0d vga=%0d data=0x%0h", gi, cyc_cnt, e.is_vga, e.data);
                end else begin
                    chk($sformatf("stray_rvalid_d%0d", gi), 32'({vga_rvalid[gi], alu_rvalid[gi]}), 32'd0);
                end
            end
        end
    endgenerate

    // One arbitration cycle: inputs already driven; check acks at the
    // falling edge, then the registered RAM command after the next rise.
    task automatic cyc(input bit ev, input bit ec, input bit ea, input bit ef, input string tag);
        @(negedge sys_clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_vga_ack", tag, d), 32'(vga_ack[d]), 32'(ev));
            chk($sformatf("%s_d%0d_cam_ack", tag, d), 32'(cam_ack[d]), 32'(ec));
            chk($sformatf("%s_d%0d_alu_ack", tag, d), 32'(alu_ack[d]), 32'(ea));
            chk($sformatf("%s_d%0d_starve", tag, d), 32'(starve_flag[d]), 32'(ef));
        end
        exp_en = ev | ec | ea;
        exp_we = ec | (ea & alu_we);
        if (ev) begin
            exp_addr = vga_addr;
        end else if (ec) begin
            exp_addr  = cam_addr;
            exp_wdata = cam_wdata;
            exp_mem[cam_addr[16:0]] = cam_wdata;
        end else if (ea) begin
            exp_addr = alu_addr;
            if (alu_we) begin
                exp_wdata = alu_wdata;
                exp_mem[alu_addr[16:0]] = alu_wdata;
            end
        end
        pend_rd   = ev | (ea & ~alu_we);
        pend_vga  = ev;
        pend_data = exp_mem[exp_addr[16:0]];
        pend_cyc  = cyc_cnt;
        $display("txn %s cyc=%0d en=%0d we=%0d addr=0x%0h", tag, cyc_cnt, exp_en, exp_we, exp_addr);
        @(posedge sys_clk);
        #1;
        pend_rd = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_mem_en", tag, d), 32'(mem_en[d]), 32'(exp_en));
            chk($sformatf("%s_d%0d_mem_we", tag, d), 32'(mem_we[d]), 32'(exp_we));
            chk($sformatf("%s_d%0d_mem_addr", tag, d), 32'(mem_addr[d]), 32'(exp_addr));
            chk($sformatf("%s_d%0d_mem_wdata", tag, d), 32'(mem_wdata[d]), 32'(exp_wdata));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_acks", tag, d), 32'({vga_ack[d], cam_ack[d], alu_ack[d]}), 32'd0);
            chk($sformatf("%s_d%0d_rvalids", tag, d), 32'({vga_rvalid[d], alu_rvalid[d]}), 32'd0);
            chk($sformatf("%s_d%0d_vga_rdata", tag, d), 32'(vga_rdata[d]), 32'd0);
            chk($sformatf("%s_d%0d_alu_rdata", tag, d), 32'(alu_rdata[d]), 32'd0);
            chk($sformatf("%s_d%0d_mem_en_we", tag, d), 32'({mem_en[d], mem_we[d]}), 32'd0);
            chk($sformatf("%s_d%0d_mem_addr", tag, d), 32'(mem_addr[d]), 32'd0);
            chk($sformatf("%s_d%0d_mem_wdata", tag, d), 32'(mem_wdata[d]), 32'd0);
            chk($sformatf("%s_d%0d_starve", tag, d), 32'(starve_flag[d]), 32'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < MEM_WORDS; k++) exp_mem[k] = init_val(19'(k));
        rst_n = 1'b1;
        cam_req = 1'b0; cam_addr = '0; cam_wdata = '0;
        vga_req = 1'b0; vga_addr = '0;
        alu_req = 1'b0; alu_we = 1'b0; alu_addr = '0; alu_wdata = '0;
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;

        // Reset state
        #1 rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check_zero("reset");
        @(posedge sys_clk); #1;
        rst_n = 1'b1;

        // Single ALU write, then an idle cycle (address/data hold)
        alu_req = 1'b1; alu_we = 1'b1; alu_addr = 19'h00010; alu_wdata = 12'hABC;
        cyc(0, 0, 1, 0, "alu_wr");
        alu_req = 1'b0;
        cyc(0, 0, 0, 0, "idle_a");

        // VGA read of a pre-loaded word (0x5A5 at 0x12C00)
        vga_req = 1'b1; vga_addr = 19'h12C00;
        cyc(1, 0, 0, 0, "vga_rd");
        vga_req = 1'b0;
        repeat (4) cyc(0, 0, 0, 0, "idle_b");

        // All three at once: VGA, then CAM, then ALU reading CAM's word
        vga_req = 1'b1; vga_addr = 19'h00100;
        cam_req = 1'b1; cam_addr = 19'h00200; cam_wdata = 12'h123;
        alu_req = 1'b1; alu_we = 1'b0; alu_addr = 19'h00200;
        cyc(1, 0, 0, 0, "all3_vga");
        vga_req = 1'b0;
        cyc(0, 1, 0, 0, "all3_cam");
        cam_req = 1'b0;
        cyc(0, 0, 1, 0, "all3_alu");
        alu_req = 1'b0;
        repeat (4) cyc(0, 0, 0, 0, "idle_c");

        // Starvation: CAM held, ALU wins on the 16th cycle
        cam_req = 1'b1; cam_addr = 19'h01000; cam_wdata = 12'h0F0;
        alu_req = 1'b1; alu_we = 1'b1; alu_addr = 19'h02000; alu_wdata = 12'h777;
        for (int i = 1; i <= 15; i++) cyc(0, 1, 0, 0, $sformatf("starve_cam%0d", i));
        cyc(0, 0, 1, 1, "starve_alu");
        alu_addr = 19'h02001; alu_wdata = 12'h778;
        cyc(0, 1, 0, 0, "starve_clr");
        cam_req = 1'b0;
        cyc(0, 0, 1, 0, "starve_alu2");
        alu_req = 1'b0;
        repeat (2) cyc(0, 0, 0, 0, "idle_d");

        // Back-to-back ALU read / VGA read / ALU read, then write+read
        alu_req = 1'b1; alu_we = 1'b0; alu_addr = 19'h00010;
        cyc(0, 0, 1, 0, "il_alu1");
        alu_req = 1'b0;
        vga_req = 1'b1; vga_addr = 19'h02000;
        cyc(1, 0, 0, 0, "il_vga");
        vga_req = 1'b0;
        alu_req = 1'b1; alu_addr = 19'h01000;
        cyc(0, 0, 1, 0, "il_alu2");
        alu_we = 1'b1; alu_addr = 19'h03333; alu_wdata = 12'hE1E;
        cyc(0, 0, 1, 0, "il_wr");
        alu_we = 1'b0;
        cyc(0, 0, 1, 0, "il_rd");
        alu_req = 1'b0;
        repeat (6) cyc(0, 0, 0, 0, "idle_e");

        // Reset while an ALU read is in flight: its return is discarded
        alu_req = 1'b1; alu_we = 1'b0; alu_addr = 19'h00200;
        cyc(0, 0, 1, 0, "rst_rd");
        alu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        exp_addr = '0; exp_wdata = '0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        repeat (6) cyc(0, 0, 0, 0, "idle_f");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fbuff_arbiter.md
Name: fbuff_arbiter

Overview:
- Shares the single-port frame-buffer RAM among three requesters: camera write path, VGA scan-out read, and ALU kernel engine (read and write).
- Sits between those requesters and the frame-buffer BRAM; replaces ad-hoc port muxing inside the memory controller.
- Fixed-priority arbitration with an ALU anti-starvation override.
- Read-return pipeline routes read data back to the requester that issued the read.

Parameters:
- AW, 19, frame-buffer address width (640x480 = 307200 words).
- DW, 12, pixel word width (4-bit R/G/B).
- RD_LAT, 1, BRAM read latency in cycles from mem_en to mem_rdata valid; legal 1..4.
- STARVE_MAX, 15, consecutive cycles the ALU may wait before it overrides the camera; legal 1..255.

Ports:
- sys_clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- cam_req  in  1  camera write request; held with addr/data until cam_ack
- cam_addr  in  AW  camera write address
- cam_wdata  in  DW  camera write data
- cam_ack  out  1  camera request accepted this cycle
- vga_req  in  1  VGA read request; held until vga_ack
- vga_addr  in  AW  VGA read address
- vga_ack  out  1  VGA request accepted this cycle
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  DW  VGA read data
- alu_req  in  1  ALU request; held until alu_ack
- alu_we  in  1  1 = write, 0 = read
- alu_addr  in  AW  ALU address
- alu_wdata  in  DW  ALU write data
- alu_ack  out  1  ALU request accepted this cycle
- alu_rvalid  out  1  alu_rdata valid
- alu_rdata  out  DW  ALU read data
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data
- starve_flag  out  1  ALU override active this cycle (debug)

Behaviour:
- Clocking and reset: one clock, sys_clk. rst_n is asynchronous and active-low.
- Reset values: all acks, rvalids, mem_en, mem_we and starve_flag = 0; mem_addr, mem_wdata, vga_rdata, alu_rdata = 0; starve counter = 0; read-tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced for them after reset is released.
- Acks are combinational from the req inputs and the registered starve state. At most one ack per cycle. A transfer occurs on a cycle with req && ack.
- Priority, normal case: VGA > CAM > ALU.
- Priority, override case: when starve_cnt == STARVE_MAX, ALU > CAM and starve_flag = 1. VGA is never overridden.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle alu_req=1 && alu_ack=0.
  - Clears on alu_ack, or when alu_req=0.
- Memory command is registered. The granted transfer in cycle N appears on mem_en/mem_we/mem_addr/mem_wdata in cycle N+1.
  - With no grant, mem_en=0 and mem_we=0 in N+1; mem_addr/mem_wdata hold their last values.
  - mem_wdata is updated only on writes.
- Read return:
  - A 2-bit tag {vga, alu} enters a shift pipeline of depth RD_LAT+1 at grant.
  - In cycle N+1+RD_LAT, the matching rvalid is 1 for exactly one cycle and that requester's rdata register captures mem_rdata.
  - Non-matching rdata holds its value. Writes produce no rvalid.
- Throughput: one transfer per cycle, back-to-back. Reads and writes may interleave with no bubbles; order equals grant order.
- Simultaneous events:
  - All three requesting: VGA wins.
  - CAM and ALU both requesting with starve_cnt < STARVE_MAX: CAM wins.
- No requests: no acks, mem_en=0, counter cleared.
- Requester rules: changing addr/data while req=1 and not acked is a protocol error. Dropping req before ack is allowed; the request is simply withdrawn.

Test Plan:
- Reset then single ALU write: alu_req=1, alu_we=1, alu_addr=0x00010, alu_wdata=0xABC -> alu_ack same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x00010, mem_wdata=0xABC; no alu_rvalid.
- VGA read, RD_LAT=1, RAM model returns 0x5A5 at addr 0x12C00: vga_ack in cycle N -> mem_en=1, mem_we=0 in N+1 -> vga_rvalid=1, vga_rdata=0x5A5 in N+2 only.
- All three requesting in the same cycle -> order of acks VGA, CAM, ALU on three consecutive cycles; mem_addr sequence matches.
- cam_req held continuously with alu_req=1, STARVE_MAX=15 -> alu_ack exactly on the 16th cycle with starve_flag=1; cam_ack deasserted that cycle; counter returns to 0.
- Interleaved ALU read / VGA read / ALU read back-to-back, RD_LAT=3 -> three rvalid pulses on consecutive cycles, routed alu, vga, alu with data from each address.
- Issue ALU read, assert rst_n=0 before it returns, release -> alu_rvalid never asserted; all outputs 0 during reset.
